// File: rtl/branch_resolve_ctrl.sv
// Branch predictor sequencing between fetch and execute: in-flight queue, resolve
// matching, mispredict flush/redirect, table-update scheduling, committed GHR.
//
// state    | meaning
// ST_RUN   | normal operation, pushes and resolves accepted
// ST_FLUSH | one-cycle mispredict pulse, pushes refused
module branch_resolve_ctrl #(
  parameter int ADDR_LENGTH = 22,
  parameter int INDEX_BITS  = 8,
  parameter int DEPTH       = 4,
  parameter int GHR_BITS    = 8
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_Pred_valid,
  input  logic [INDEX_BITS-1:0]  i_Pred_index,
  input  logic                   i_Pred_taken,
  input  logic [ADDR_LENGTH-1:0] i_Pred_pc,
  output logic                   o_Pred_ready,
  input  logic                   i_Res_valid,
  input  logic                   i_Res_outcome,
  input  logic [ADDR_LENGTH-1:0] i_Res_target,
  output logic                   o_Res_ready,
  output logic                   o_Flush,
  output logic [ADDR_LENGTH-1:0] o_Redirect_pc,
  output logic                   o_Upd_valid,
  output logic [INDEX_BITS-1:0]  o_Upd_index,
  output logic                   o_Upd_taken,
  input  logic                   i_Upd_ready,
  output logic [GHR_BITS-1:0]    o_Ghr,
  output logic [15:0]            o_Mispredict_count,
  output logic                   o_Error
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t state, state_next;

  logic [INDEX_BITS-1:0]  q_index [DEPTH];
  logic [ADDR_LENGTH-1:0] q_pc    [DEPTH];
  logic [DEPTH-1:0]       q_taken;

  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;

  logic                   upd_valid;
  logic [INDEX_BITS-1:0]  upd_index;
  logic                   upd_taken;
  logic [GHR_BITS-1:0]    ghr;
  logic [15:0]            mis_count;
  logic [ADDR_LENGTH-1:0] redirect_pc;
  logic                   error;

  logic push, res_acc, pop, mispredict;

  assign o_Pred_ready = (count != FULL) & (state == ST_RUN);
  assign o_Res_ready  = !upd_valid | i_Upd_ready;

  assign push       = i_Pred_valid & o_Pred_ready;
  assign res_acc    = i_Res_valid & o_Res_ready;
  assign pop        = res_acc & (count != '0);
  assign mispredict = pop & (i_Res_outcome != q_taken[head]);

  always_ff @(posedge i_Clk) begin
    if (i_Reset) state <= ST_RUN;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:   if (mispredict) state_next = ST_FLUSH;
      ST_FLUSH: state_next = ST_RUN;
      default:  state_next = ST_RUN;
    endcase
  end

  // Entry storage needs no reset; validity is tracked by count.
  always_ff @(posedge i_Clk) begin
    if (push) begin
      q_index[tail] <= i_Pred_index;
      q_taken[tail] <= i_Pred_taken;
      q_pc[tail]    <= i_Pred_pc;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      upd_valid   <= 1'b0;
      upd_index   <= '0;
      upd_taken   <= 1'b0;
      ghr         <= '0;
      mis_count   <= '0;
      redirect_pc <= '0;
      error       <= 1'b0;
    end else begin
      // A mispredict discards everything younger, including this cycle's push.
      if (mispredict) begin
        count <= '0;
        head  <= head + 1'b1;
        tail  <= head + 1'b1;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end

      if (pop) begin
        upd_valid <= 1'b1;
        upd_index <= q_index[head];
        upd_taken <= i_Res_outcome;
        ghr       <= {ghr[GHR_BITS-2:0], i_Res_outcome};
      end else if (i_Upd_ready) begin
        upd_valid <= 1'b0;
      end

      if (mispredict) begin
        redirect_pc <= i_Res_outcome ? i_Res_target : q_pc[head] + 1'b1;
        if (mis_count != 16'hFFFF) mis_count <= mis_count + 16'd1;
      end

      if (res_acc && count == '0) error <= 1'b1;
    end
  end

  assign o_Flush            = (state == ST_FLUSH);
  assign o_Redirect_pc      = redirect_pc;
  assign o_Upd_valid        = upd_valid;
  assign o_Upd_index        = upd_index;
  assign o_Upd_taken        = upd_taken;
  assign o_Ghr              = ghr;
  assign o_Mispredict_count = mis_count;
  assign o_Error            = error;

endmodule
